horner_eval_ctrl: RTL and testbench

Parametrised iterative polynomial evaluator: computes y = c[D]·x^D + … + c[1]·x + c[0] in signed fixed point by Horner's rule, using one multiplier and one adder reused over 2·D cycles. The controller FSM and datapath are in one block, and the block has an internal coefficient register file. It succeeds the fixed-degree multiply/add sequencer: width, fraction bits and maximum degree are generic, the degree is chosen per run, and the results saturate and report overflow. It keeps the team's start/ready handshake, including the "wait for start release" arming.

---
 rtl/horner_eval_ctrl.sv | 133 +++++++++++++
 tb/tb_horner_eval_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/horner_eval_ctrl.sv
// Iterative Horner-rule polynomial evaluator in signed fixed point, one multiplier and one adder.
// It has an internal coefficient register file and a start/ready handshake that arms on release.
module horner_eval_ctrl #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned FRAC    = 8,
    parameter int unsigned MAX_DEG = 4,
    parameter int unsigned DW      = $clog2(MAX_DEG + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in,
    input  logic [DW-1:0]    deg_in,
    input  logic             coef_we,
    input  logic [DW-1:0]    coef_addr,
    input  logic [WIDTH-1:0] coef_data,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y_out,
    output logic             ovf
);

    typedef enum logic [2:0] {StIdle, StArm, StMul, StAdd, StDone} state_e;

    localparam logic [DW-1:0]    MaxDeg = DW'(MAX_DEG);
    localparam logic [WIDTH-1:0] SatMax = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] SatMin = {1'b1, {(WIDTH - 1){1'b0}}};

    state_e state_q, state_d;
    logic signed [WIDTH-1:0] acc_q, acc_d, tmp_q, tmp_d, x_q, x_d, y_q, y_d;
    logic [DW-1:0]           deg_q, deg_d, idx_q, idx_d;
    logic                    ovf_q, ovf_d;
    logic signed [WIDTH-1:0] coef_q [MAX_DEG+1];

    logic signed [2*WIDTH-1:0] prod, prod_sh;
    logic signed [WIDTH:0]     sum;
    logic signed [WIDTH-1:0]   coef_rd, mul_sat, add_sat;
    logic                      mul_ovf, add_ovf;

    // Product is in range only if the bits above the result sign all equal it.
    always_comb begin
        prod    = acc_q * x_q;
        prod_sh = prod >>> FRAC;
        mul_ovf = ~((&prod_sh[2*WIDTH-1:WIDTH-1]) | ~(|prod_sh[2*WIDTH-1:WIDTH-1]));
        mul_sat = mul_ovf ? (prod_sh[2*WIDTH-1] ? SatMin : SatMax) : prod_sh[WIDTH-1:0];
        coef_rd = coef_q[idx_q];
        sum     = {tmp_q[WIDTH-1], tmp_q} + {coef_rd[WIDTH-1], coef_rd};
        add_ovf = sum[WIDTH] ^ sum[WIDTH-1];
        add_sat = add_ovf ? (sum[WIDTH] ? SatMin : SatMax) : sum[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        tmp_d   = tmp_q;
        x_d     = x_q;
        y_d     = y_q;
        deg_d   = deg_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    x_d     = x_in;
                    deg_d   = (deg_in > MaxDeg) ? MaxDeg : deg_in;
                    ovf_d   = 1'b0;
                    state_d = StArm;
                end
            end
            StArm: begin
                acc_d = coef_q[deg_q];
                idx_d = deg_q;
                if (!start) begin
                    state_d = (deg_q == '0) ? StDone : StMul;
                end
            end
            StMul: begin
                tmp_d   = mul_sat;
                idx_d   = idx_q - 1'b1;
                ovf_d   = ovf_q | mul_ovf;
                state_d = StAdd;
            end
            StAdd: begin
                acc_d   = add_sat;
                ovf_d   = ovf_q | add_ovf;
                state_d = (idx_q == '0) ? StDone : StMul;
            end
            StDone: begin
                y_d     = acc_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            tmp_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            deg_q   <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i <= int'(MAX_DEG); i++) begin
                coef_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            tmp_q   <= tmp_d;
            x_q     <= x_d;
            y_q     <= y_d;
            deg_q   <= deg_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            if (coef_we && state_q == StIdle && coef_addr <= MaxDeg) begin
                coef_q[coef_addr] <= coef_data;
            end
        end
    end

    always_comb begin
        ready = (state_q == StIdle);
        busy  = (state_q == StArm) || (state_q == StMul) || (state_q == StAdd);
        done  = (state_q == StDone);
        y_out = y_q;
        ovf   = ovf_q;
    end

endmodule

// File: tb/tb_horner_eval_ctrl.sv
// Randomised and directed bench for horner_eval_ctrl against a plain-arithmetic Horner model.
module tb_horner_eval_ctrl;

    localparam int WIDTH   = 16;
    localparam int FRAC    = 8;
    localparam int MAX_DEG = 4;
    localparam int DW      = 3;
    localparam longint MAXV = (64'sd1 <<< (WIDTH - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (WIDTH - 1));

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] x_in = '0;
    logic [DW-1:0]    deg_in = '0;
    logic             coef_we = 1'b0;
    logic [DW-1:0]    coef_addr = '0;
    logic [WIDTH-1:0] coef_data = '0;
    logic             ready, busy, done, ovf;
    logic [WIDTH-1:0] y_out;

    int n_cmp = 0;
    int n_bad = 0;
    longint cm [0:MAX_DEG];
    bit m_ovf;

    horner_eval_ctrl #(.WIDTH(WIDTH), .FRAC(FRAC), .MAX_DEG(MAX_DEG)) dut (
        .clk(clk), .rst(rst), .start(start), .x_in(x_in), .deg_in(deg_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .ready(ready), .busy(busy), .done(done), .y_out(y_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sat_m(input longint v);
        if (v > MAXV) begin m_ovf = 1'b1; return MAXV; end
        if (v < MINV) begin m_ovf = 1'b1; return MINV; end
        return v;
    endfunction

    // y = sum c[i]*x^i evaluated from the top coefficient down.
    function automatic longint horner_m(input longint x, input int d);
        longint acc = cm[d];
        m_ovf = 1'b0;
        for (int i = d - 1; i >= 0; i--) begin
            acc = sat_m((acc * x) >>> FRAC);
            acc = sat_m(acc + cm[i]);
        end
        return acc;
    endfunction

    function automatic longint sx(input logic [WIDTH-1:0] v);
        return longint'($signed(v));
    endfunction

    // Called just after a falling edge; returns just after the next one.
    task automatic write_coef(input int addr, input logic [WIDTH-1:0] data);
        coef_we   = 1'b1;
        coef_addr = DW'(addr);
        coef_data = data;
        if (addr <= MAX_DEG) cm[addr] = sx(data);
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // mode 0: no write; 1: write c0=0x5555 during the first MUL; 2: write with capture.
    task automatic run(input logic [WIDTH-1:0] x, input int deg, input int hold, input int mode,
                       input int waddr, input logic [WIDTH-1:0] wdata);
        int degc, cnt;
        bit got;
        longint exp_y;
        degc = (deg > MAX_DEG) ? MAX_DEG : deg;
        start = 1'b1; x_in = x; deg_in = DW'(deg);
        if (mode == 2) begin
            coef_we = 1'b1; coef_addr = DW'(waddr); coef_data = wdata;
            if (waddr <= MAX_DEG) cm[waddr] = sx(wdata);
        end
        exp_y = horner_m(sx(x), degc);
        @(negedge clk);
        coef_we = 1'b0;
        for (int h = 0; h < hold; h++) begin
            check("arm_hold_busy", busy, 1);
            check("arm_hold_done", done, 0);
            @(negedge clk);
        end
        check("arm_busy", busy, 1);
        check("arm_ready", ready, 0);
        start = 1'b0;
        cnt = 0; got = 1'b0;
        while (cnt < 64 && !got) begin
            @(negedge clk);
            cnt++;
            coef_we = (mode == 1 && cnt == 1);
            coef_addr = '0; coef_data = 16'h5555;
            if (done) got = 1'b1;
            else check("run_busy", busy, 1);
        end
        coef_we = 1'b0;
        check("done_latency", got ? cnt : -1, 2 * degc + 1);
        @(negedge clk);
        check("y_out", sx(y_out), exp_y);
        check("ovf", ovf, m_ovf);
        check("ready_after", ready, 1);
        check("done_pulse", done, 0);
    endtask

    initial begin
        for (int i = 0; i <= MAX_DEG; i++) cm[i] = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_y", sx(y_out), 0);
        check("rst_ovf", ovf, 0);

        write_coef(0, 16'h0100); write_coef(1, 16'h0100); write_coef(2, 16'h0100);
        run(16'h0200, 2, 0, 0, 0, 0);
        check("dir_y_7", sx(y_out), 16'h0700);
        run(16'hFF00, 2, 0, 0, 0, 0);
        check("dir_y_neg", sx(y_out), 16'h0100);
        run(16'hFF00, 7, 0, 0, 0, 0);
        write_coef(0, 16'h1234);
        run(16'h0300, 0, 0, 0, 0, 0);
        check("dir_deg0", sx(y_out), 16'h1234);

        write_coef(1, 16'h7F00); write_coef(0, 16'h0000);
        run(16'h7F00, 1, 0, 0, 0, 0);
        check("dir_sat_y", sx(y_out), 16'h7FFF);
        check("dir_sat_ovf", ovf, 1);
        run(16'h0100, 1, 0, 0, 0, 0);
        check("dir_ovf_clr", ovf, 0);

        run(16'h0100, 2, 3, 1, 0, 0);
        run(16'h0100, 0, 0, 0, 0, 0);
        check("dir_c0_kept", sx(y_out), 0);
        run(16'h0100, 0, 0, 2, 0, 16'h0777);
        check("dir_cap_write", sx(y_out), 16'h0777);
        write_coef(5, 16'h1111);
        run(16'h0100, 0, 0, 0, 0, 0);

        // Abort a deg-3 run in ADD after an overflowing MUL.
        write_coef(3, 16'h7F00);
        start = 1'b1; x_in = 16'h7F00; deg_in = 3'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_add", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", ready, 1);
        check("abort_done", done, 0);
        check("abort_y", sx(y_out), 0);
        check("abort_ovf", ovf, 0);
        for (int i = 0; i <= MAX_DEG; i++) cm[i] = 0;
        run(16'h0100, 3, 0, 0, 0, 0);
        check("abort_cleared", sx(y_out), 0);

        for (int it = 0; it < 30; it++) begin
            int nw = $urandom_range(0, 4);
            for (int w = 0; w < nw; w++) begin
                logic [WIDTH-1:0] d;
                if ($urandom_range(0, 3) == 0) d = WIDTH'($urandom);
                else d = WIDTH'(int'($urandom_range(0, 1024)) - 512);
                write_coef($urandom_range(0, 7), d);
            end
            begin
                logic [WIDTH-1:0] xv, wd;
                if ($urandom_range(0, 3) == 0) xv = WIDTH'($urandom);
                else xv = WIDTH'(int'($urandom_range(0, 1024)) - 512);
                wd = WIDTH'($urandom);
                run(xv, $urandom_range(0, 7), $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 7), wd);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
